// File: rtl/ble4_cfg_pkg.sv
// Shared constants and types for the BLE4 LUT configuration tile.
//   LUT_K      : LUT input count
//   CFG_BITS   : configuration chain length (truth table plus mode bit)
//   MODE_BIT   : chain index of the output-mode bit
//   cfg_state_t: load state machine encoding
package ble4_cfg_pkg;

  localparam int unsigned LUT_K    = 4;
  localparam int unsigned CFG_BITS = (1 << LUT_K) + 1;
  localparam int unsigned MODE_BIT = 1 << LUT_K;

  typedef enum logic [1:0] {
    UNCONFIG   = 2'd0,
    LOADING    = 2'd1,
    CONFIGURED = 2'd2
  } cfg_state_t;

endpackage

// File: rtl/lut4_mux.sv
// Combinational truth-table lookup for the BLE4 LUT.
//   truth   : in  truth table, truth[n] is the result for sel == n
//   sel     : in  LUT inputs
//   lut_out : out selected truth bit
module lut4_mux #(
  parameter int unsigned LUT_K = 4
) (
  input  logic [(1 << LUT_K)-1:0] truth,
  input  logic [LUT_K-1:0]        sel,
  output logic                    lut_out
);

  assign lut_out = truth[sel];

endmodule

// File: rtl/ble4_lut4_cfg.sv
// Configurable 4-input LUT with serial configuration chain and output-mode
// select between combinational and registered results.
//   clk       : in  clock
//   reset     : in  synchronous active-low reset
//   cfg_en    : in  chain shift enable
//   ccff_head : in  serial config data in
//   ccff_tail : out serial config data out (last chain stage)
//   lut_in    : in  LUT inputs
//   ff_D      : out LUT result to the flip-flop D input
//   ff_Q      : in  flip-flop output
//   ble_out   : out BLE output
//   cfg_done  : out configuration valid
//   cfg_err   : out last load had the wrong length (sticky)
module ble4_lut4_cfg #(
  parameter int unsigned LUT_K    = 4,
  parameter int unsigned CFG_BITS = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_en,
  input  logic             ccff_head,
  output logic             ccff_tail,
  input  logic [LUT_K-1:0] lut_in,
  output logic             ff_D,
  input  logic             ff_Q,
  output logic             ble_out,
  output logic             cfg_done,
  output logic             cfg_err
);

  import ble4_cfg_pkg::*;

  localparam int unsigned CntW = $clog2(CFG_BITS + 1);

  cfg_state_t          state_q, state_d;
  logic [CFG_BITS-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                shift;
  logic                lut_out;
  logic                configured;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;
    shift   = 1'b0;
    unique case (state_q)
      UNCONFIG, CONFIGURED: begin
        if (cfg_en) begin
          // The entry cycle already shifts the first bit, so the count starts at 1.
          state_d = LOADING;
          shift   = 1'b1;
          cnt_d   = CntW'(1);
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      LOADING: begin
        if (cfg_en) begin
          shift = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + CntW'(1);
        end else if (cnt_q == CntW'(CFG_BITS)) begin
          state_d = CONFIGURED;
          done_d  = 1'b1;
        end else begin
          // Wrong length: sreg is kept so the chain tail keeps passing data.
          state_d = UNCONFIG;
          err_d   = 1'b1;
        end
      end
      default: state_d = UNCONFIG;
    endcase
  end

  always_comb begin
    sreg_d = sreg_q;
    if (shift) sreg_d = {sreg_q[CFG_BITS-2:0], ccff_head};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= UNCONFIG;
      sreg_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  lut4_mux #(
    .LUT_K (LUT_K)
  ) u_lut4_mux (
    .truth   (sreg_q[MODE_BIT-1:0]),
    .sel     (lut_in),
    .lut_out (lut_out)
  );

  assign configured = (state_q == CONFIGURED);
  assign ccff_tail  = sreg_q[CFG_BITS-1];
  assign ff_D       = configured & lut_out;
  assign ble_out    = configured & (sreg_q[MODE_BIT] ? ff_Q : lut_out);
  assign cfg_done   = done_q;
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_ble4_lut4_cfg.sv
// Directed self-checking bench for ble4_lut4_cfg.
module tb_ble4_lut4_cfg;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_en;
  logic       ccff_head;
  logic       ccff_tail;
  logic [3:0] lut_in;
  logic       ff_D;
  logic       ff_Q;
  logic       ble_out;
  logic       cfg_done;
  logic       cfg_err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ble4_lut4_cfg #(
    .LUT_K    (4),
    .CFG_BITS (17)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_en    (cfg_en),
    .ccff_head (ccff_head),
    .ccff_tail (ccff_tail),
    .lut_in    (lut_in),
    .ff_D      (ff_D),
    .ff_Q      (ff_Q),
    .ble_out   (ble_out),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    cfg_en    = 1'b1;
    ccff_head = b;
    tick();
  endtask

  // Shifts the first nbits of the stream {mode, truth[15], ..., truth[0]}.
  task automatic load(input logic mode, input logic [15:0] truth, input int nbits);
    logic [16:0] stream;
    stream = {mode, truth};
    for (int i = 16; i > 16 - nbits; i--) shift_bit(stream[i]);
    cfg_en = 1'b0;
    tick();
  endtask

  initial begin
    logic [33:0] pat;
    logic        acc;

    // Reset with random inputs
    reset     = 1'b0;
    cfg_en    = 1'($urandom);
    ccff_head = 1'($urandom);
    lut_in    = 4'($urandom);
    ff_Q      = 1'($urandom);
    tick();
    tick();
    check("rst_ff_D", {31'd0, ff_D}, 32'd0);
    check("rst_ble_out", {31'd0, ble_out}, 32'd0);
    check("rst_tail", {31'd0, ccff_tail}, 32'd0);
    check("rst_done", {31'd0, cfg_done}, 32'd0);
    check("rst_err", {31'd0, cfg_err}, 32'd0);
    reset  = 1'b1;
    cfg_en = 1'b0;
    ff_Q   = 1'b0;

    // AND4, combinational mode
    load(1'b0, 16'h8000, 17);
    check("and_done", {31'd0, cfg_done}, 32'd1);
    check("and_err", {31'd0, cfg_err}, 32'd0);
    lut_in = 4'hF;
    #1;
    check("and_F_ff_D", {31'd0, ff_D}, 32'd1);
    check("and_F_ble", {31'd0, ble_out}, 32'd1);
    lut_in = 4'hE;
    #1;
    check("and_E_ff_D", {31'd0, ff_D}, 32'd0);
    check("and_E_ble", {31'd0, ble_out}, 32'd0);

    // XOR4, registered mode; outputs gated from the first loading cycle
    lut_in = 4'hF;
    shift_bit(1'b1);
    check("load_gate_ff_D", {31'd0, ff_D}, 32'd0);
    check("load_gate_done", {31'd0, cfg_done}, 32'd0);
    for (int i = 15; i >= 0; i--) begin
      logic [15:0] tt;
      tt = 16'h6996;
      shift_bit(tt[i]);
    end
    cfg_en = 1'b0;
    tick();
    check("xor_done", {31'd0, cfg_done}, 32'd1);
    lut_in = 4'h1;
    ff_Q   = 1'b0;
    #1;
    check("xor_1_ff_D", {31'd0, ff_D}, 32'd1);
    check("xor_q0_ble", {31'd0, ble_out}, 32'd0);
    ff_Q = 1'b1;
    #1;
    check("xor_q1_ble", {31'd0, ble_out}, 32'd1);
    lut_in = 4'h3;
    #1;
    check("xor_3_ff_D", {31'd0, ff_D}, 32'd0);
    check("xor_3_q1_ble", {31'd0, ble_out}, 32'd1);
    ff_Q = 1'b0;

    // Short load (16 bits)
    load(1'b0, 16'hFFFF, 16);
    check("short_err", {31'd0, cfg_err}, 32'd1);
    check("short_done", {31'd0, cfg_done}, 32'd0);
    acc = 1'b0;
    for (int n = 0; n < 16; n++) begin
      lut_in = 4'(n);
      #1;
      acc = acc | ff_D | ble_out;
    end
    check("short_outs_zero", {31'd0, acc}, 32'd0);
    load(1'b0, 16'hFFFE, 17);
    check("reload_err", {31'd0, cfg_err}, 32'd0);
    check("reload_done", {31'd0, cfg_done}, 32'd1);
    lut_in = 4'h0;
    #1;
    check("or_0_ff_D", {31'd0, ff_D}, 32'd0);
    lut_in = 4'h9;
    #1;
    check("or_9_ff_D", {31'd0, ff_D}, 32'd1);

    // Chain pass-through with overrun
    pat = 34'h2_B5A3_C96E;
    for (int i = 1; i <= 34; i++) begin
      shift_bit(pat[i-1]);
      if (i >= 17) check($sformatf("chain_tail_%0d", i), {31'd0, ccff_tail},
                         {31'd0, pat[i-17]});
    end
    cfg_en = 1'b0;
    tick();
    check("overrun_err", {31'd0, cfg_err}, 32'd1);
    check("overrun_done", {31'd0, cfg_done}, 32'd0);

    // Reset mid-load
    for (int i = 0; i < 8; i++) shift_bit(1'b1);
    cfg_en = 1'b0;
    reset  = 1'b0;
    tick();
    check("midrst_tail", {31'd0, ccff_tail}, 32'd0);
    check("midrst_done", {31'd0, cfg_done}, 32'd0);
    check("midrst_err", {31'd0, cfg_err}, 32'd0);
    check("midrst_ff_D", {31'd0, ff_D}, 32'd0);
    reset = 1'b1;
    load(1'b0, 16'h8000, 17);
    check("post_rst_done", {31'd0, cfg_done}, 32'd1);
    lut_in = 4'hF;
    #1;
    check("post_rst_ff_D", {31'd0, ff_D}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
